fan_speed_ctrl: RTL and testbench



---
 rtl/fan_pkg.sv | 46 ++++
 rtl/fan_pwm_gen.sv | 39 +++
 rtl/fan_speed_ctrl.sv | 128 ++++++++++++
 tb/tb_fan_speed_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared types and elaboration-time helpers for the fan speed controller.
package fan_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD,
    CMD_UP,
    CMD_DOWN,
    CMD_OFF
  } lvl_cmd_e;

  function automatic int unsigned level_width(input int unsigned levels);
    return (levels < 1) ? 1 : $clog2(levels + 1);
  endfunction

  localparam int unsigned LEVELS_MAX = 255;
  localparam int unsigned LW_MAX     = level_width(LEVELS_MAX);

  // floor(k * (2^n - 1) / levels) evaluated in 64-bit to avoid overflow.
  function automatic longint unsigned target_duty(input int unsigned k,
                                                  input int unsigned levels,
                                                  input int unsigned n);
    longint unsigned kk;
    longint unsigned full;
    longint unsigned lv;
    kk   = k;
    lv   = levels;
    full = (64'd1 << n) - 64'd1;
    if (lv == 64'd0) return 64'd0;
    return (kk * full) / lv;
  endfunction

  function automatic int unsigned div_calc(input int unsigned sys_mhz,
                                           input int unsigned pwm_hz,
                                           input int unsigned n);
    longint unsigned num;
    longint unsigned den;
    longint unsigned q;
    num = sys_mhz;
    num = num * 64'd1000000;
    den = pwm_hz;
    den = den << n;
    q   = (den == 64'd0) ? 64'd1 : num / den;
    return (q < 64'd1) ? 1 : 32'(q);
  endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Fixed-frequency PWM: prescaler, N-bit period counter and registered comparator.
module fan_pwm_gen
  import fan_pkg::*;
#(
  parameter int unsigned SYS_FREQ = 125,
  parameter int unsigned N        = 12,
  parameter int unsigned PWM_FREQ = 200
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] duty,
  output logic         pwm
);

  localparam int unsigned   DIV        = div_calc(SYS_FREQ, PWM_FREQ, N);
  localparam int unsigned   PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic [N-1:0]  cnt;
  logic          tick;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      cnt   <= '0;
      pwm   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
      // Full-scale duty must stay high through the cnt == 2^N-1 slot.
      if (duty == '1) pwm <= 1'b1;
      else            pwm <= (cnt < duty);
    end
  end

endmodule

// File: rtl/fan_speed_ctrl.sv
// Fan speed controller: level control, registered target lookup, duty/busy and PWM.
// Define FAN_SOFT_START_EN to ramp duty toward target instead of tracking it directly.
module fan_speed_ctrl
  import fan_pkg::*;
#(
  parameter int unsigned SYS_FREQ   = 125,
  parameter int unsigned N          = 12,
  parameter int unsigned LEVELS     = 7,
  parameter int unsigned PWM_FREQ   = 200,
  parameter int unsigned WRAP       = 0,
  parameter int unsigned RAMP_TICKS = 1024,
  parameter int unsigned RAMP_STEP  = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           btn_up_p,
  input  logic                           btn_down_p,
  input  logic                           fan_en,
  output logic [level_width(LEVELS)-1:0] level,
  output logic [N-1:0]                   duty,
  output logic                           busy,
  output logic                           pwm
);

  localparam int unsigned   LW        = level_width(LEVELS);
  localparam int unsigned   LUT_DEPTH = 1 << LW;
  localparam logic [LW-1:0] LVL_MAX   = LW'(LEVELS);

  if (LEVELS < 1 || LEVELS > LEVELS_MAX || N < 1 || RAMP_TICKS < 1 || RAMP_STEP < 1)
  begin : g_param_check
    $error("fan_speed_ctrl: parameter out of range");
  end

  lvl_cmd_e      cmd;
  logic [LW-1:0] level_d;
  logic [N-1:0]  target;
  logic [N-1:0]  target_d;
  logic [N-1:0]  duty_d;
  logic [N-1:0]  lut [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    assign lut[k] = (k <= LEVELS) ? N'(target_duty(k, LEVELS, N)) : '0;
  end

  always_comb begin
    cmd = CMD_HOLD;
    if (!fan_en)                       cmd = CMD_OFF;
    else if (btn_up_p && !btn_down_p)  cmd = CMD_UP;
    else if (btn_down_p && !btn_up_p)  cmd = CMD_DOWN;

    level_d = level;
    unique case (cmd)
      CMD_OFF:  level_d = '0;
      CMD_UP:   if (level >= LVL_MAX) level_d = (WRAP != 0) ? '0 : LVL_MAX;
                else                  level_d = level + 1'b1;
      CMD_DOWN: if (level == '0)      level_d = (WRAP != 0) ? LVL_MAX : '0;
                else                  level_d = level - 1'b1;
      default:  level_d = level;
    endcase
  end

  // Target drops with fan_en so busy stays clear through a forced stop.
  assign target_d = fan_en ? lut[level] : '0;

`ifdef FAN_SOFT_START_EN
  localparam int unsigned   TW        = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_TICKS - 1);
  localparam logic [N:0]    STEP      = (N+1)'((RAMP_STEP > (1 << N)) ? (1 << N) : RAMP_STEP);

  logic [TW-1:0] ramp_cnt;
  logic          ramp_tick;
  logic [N:0]    up_room;
  logic [N:0]    dn_room;

  assign ramp_tick = (ramp_cnt == TICK_LAST);

  always_comb begin
    up_room = {1'b0, target} - {1'b0, duty};
    dn_room = {1'b0, duty} - {1'b0, target};
    duty_d  = duty;
    if (!fan_en) begin
      duty_d = '0;
    end else if (ramp_tick && (target_d == target)) begin
      if (duty < target)      duty_d = (up_room > STEP) ? duty + STEP[N-1:0] : target;
      else if (duty > target) duty_d = (dn_room > STEP) ? duty - STEP[N-1:0] : target;
    end
  end

  // Timer restarts on any target change and idles once duty has arrived.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramp_cnt <= '0;
    end else if (!fan_en || (target_d != target) || (duty == target)) begin
      ramp_cnt <= '0;
    end else begin
      ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
    end
  end
`else
  assign duty_d = fan_en ? target : '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level  <= '0;
      target <= '0;
      duty   <= '0;
      busy   <= 1'b0;
    end else begin
      level  <= level_d;
      target <= target_d;
      duty   <= duty_d;
      busy   <= (duty_d != target_d);
    end
  end

  fan_pwm_gen #(
    .SYS_FREQ (SYS_FREQ),
    .N        (N),
    .PWM_FREQ (PWM_FREQ)
  ) u_pwm (
    .clk     (clk),
    .reset_n (reset_n),
    .duty    (duty),
    .pwm     (pwm)
  );

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Scoreboard bench for fan_speed_ctrl: two instances (saturating and wrapping levels).
module tb_fan_speed_ctrl;

  typedef enum int unsigned {F_LEVEL, F_DUTY, F_BUSY, F_PWM} fld_e;

  typedef struct {
    int unsigned cyc;
    int unsigned dut;
    fld_e        fld;
    int unsigned val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up0, dn0, en0, up1, dn1, en1;
  logic [1:0] level0, level1;
  logic [3:0] duty0, duty1;
  logic       busy0, busy1, pwm0, pwm1;

  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fan_speed_ctrl #(
    .SYS_FREQ(1), .N(4), .LEVELS(3), .PWM_FREQ(62500), .WRAP(0),
    .RAMP_TICKS(4), .RAMP_STEP(4)
  ) dut0 (
    .clk(clk), .reset_n(rst_n), .btn_up_p(up0), .btn_down_p(dn0), .fan_en(en0),
    .level(level0), .duty(duty0), .busy(busy0), .pwm(pwm0)
  );

  fan_speed_ctrl #(
    .SYS_FREQ(1), .N(4), .LEVELS(3), .PWM_FREQ(62500), .WRAP(1),
    .RAMP_TICKS(4), .RAMP_STEP(4)
  ) dut1 (
    .clk(clk), .reset_n(rst_n), .btn_up_p(up1), .btn_down_p(dn1), .fan_en(en1),
    .level(level1), .duty(duty1), .busy(busy1), .pwm(pwm1)
  );

  function automatic string fname(input fld_e f);
    case (f)
      F_LEVEL: return "level";
      F_DUTY:  return "duty";
      F_BUSY:  return "busy";
      default: return "pwm";
    endcase
  endfunction

  function automatic int unsigned actual(input int unsigned d, input fld_e f);
    int unsigned v;
    v = 0;
    case (f)
      F_LEVEL: v = (d == 0) ? 32'(level0) : 32'(level1);
      F_DUTY:  v = (d == 0) ? 32'(duty0)  : 32'(duty1);
      F_BUSY:  v = (d == 0) ? 32'(busy0)  : 32'(busy1);
      default: v = (d == 0) ? 32'(pwm0)   : 32'(pwm1);
    endcase
    return v;
  endfunction

  task automatic check(input string nm, input int unsigned d,
                       input int unsigned act, input int unsigned expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, d, cyc, act, expv);
    end
  endtask

  task automatic expect_at(input int unsigned c, input int unsigned d,
                           input fld_e f, input int unsigned v);
    exp_t e;
    e.cyc = c; e.dut = d; e.fld = f; e.val = v;
    sb.push_back(e);
  endtask

  // Monitor: compares every expectation stamped for the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(fname(sb[i].fld), sb[i].dut, actual(sb[i].dut, sb[i].fld), sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_%s dut%0d: stamp %0d never sampled, expected %0d",
                 fname(sb[i].fld), sb[i].dut, sb[i].cyc, sb[i].val);
        sb.delete(i);
      end
    end
  end

  // Called at a negedge; drives one single-cycle pulse, returns the launch cycle.
  task automatic pulse(input int unsigned d, input logic u, input logic dn,
                       output int unsigned c);
    c = cyc;
    if (d == 0) begin up0 = u; dn0 = dn; end
    else        begin up1 = u; dn1 = dn; end
    @(negedge clk);
    up0 = 1'b0; dn0 = 1'b0; up1 = 1'b0; dn1 = 1'b0;
  endtask

  task automatic async_reset_check(input int unsigned d);
    #2 rst_n = 1'b0;
    #1;
    check("areset_level", d, actual(d, F_LEVEL), 0);
    check("areset_duty",  d, actual(d, F_DUTY),  0);
    check("areset_busy",  d, actual(d, F_BUSY),  0);
    check("areset_pwm",   d, actual(d, F_PWM),   0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef FAN_SOFT_START_EN
  task automatic ramp_tests();
    int unsigned c;
    pulse(1, 1'b0, 1'b1, c);
    expect_at(c + 1,  1, F_LEVEL, 3);
    expect_at(c + 2,  1, F_DUTY,  0);
    expect_at(c + 2,  1, F_BUSY,  1);
    expect_at(c + 5,  1, F_DUTY,  0);
    expect_at(c + 6,  1, F_DUTY,  4);
    expect_at(c + 10, 1, F_DUTY,  8);
    expect_at(c + 14, 1, F_DUTY,  12);
    expect_at(c + 17, 1, F_BUSY,  1);
    expect_at(c + 18, 1, F_DUTY,  15);
    expect_at(c + 18, 1, F_BUSY,  0);
    repeat (20) @(negedge clk);
    pulse(1, 1'b1, 1'b0, c);
    expect_at(c + 1, 1, F_LEVEL, 0);
    expect_at(c + 6, 1, F_DUTY,  11);
    expect_at(c + 6, 1, F_BUSY,  1);
    repeat (7) @(negedge clk);
    async_reset_check(1);
  endtask
`else
  task automatic basic_tests();
    int unsigned c;
    int unsigned lv;
    int unsigned ones;
    for (int unsigned i = 0; i < 4; i++) begin
      lv = (i < 3) ? i + 1 : 3;
      pulse(0, 1'b1, 1'b0, c);
      expect_at(c + 1, 0, F_LEVEL, lv);
      expect_at(c + 2, 0, F_BUSY,  (i < 3) ? 1 : 0);
      expect_at(c + 3, 0, F_DUTY,  5 * lv);
      expect_at(c + 3, 0, F_BUSY,  0);
      repeat (4) @(negedge clk);
    end
    for (int unsigned k = 1; k <= 20; k++) expect_at(cyc + k, 0, F_PWM, 1);
    repeat (20) @(negedge clk);

    pulse(0, 1'b0, 1'b1, c);
    expect_at(c + 1, 0, F_LEVEL, 2);
    expect_at(c + 3, 0, F_DUTY,  10);
    repeat (4) @(negedge clk);

    pulse(0, 1'b1, 1'b1, c);
    expect_at(c + 1, 0, F_LEVEL, 2);
    expect_at(c + 3, 0, F_LEVEL, 2);
    expect_at(c + 3, 0, F_DUTY,  10);
    repeat (4) @(negedge clk);

    c = cyc;
    en0 = 1'b0; up0 = 1'b1;
    @(negedge clk);
    en0 = 1'b1; up0 = 1'b0;
    expect_at(c + 1, 0, F_LEVEL, 0);
    expect_at(c + 1, 0, F_DUTY,  0);
    expect_at(c + 1, 0, F_BUSY,  0);
    expect_at(c + 2, 0, F_LEVEL, 0);
    expect_at(c + 2, 0, F_PWM,   0);
    expect_at(c + 3, 0, F_DUTY,  0);
    expect_at(c + 3, 0, F_PWM,   0);
    repeat (4) @(negedge clk);

    pulse(0, 1'b0, 1'b1, c);
    expect_at(c + 1, 0, F_LEVEL, 0);
    expect_at(c + 3, 0, F_DUTY,  0);
    repeat (4) @(negedge clk);

    pulse(0, 1'b1, 1'b0, c);
    expect_at(c + 1, 0, F_LEVEL, 1);
    expect_at(c + 3, 0, F_DUTY,  5);
    repeat (6) @(negedge clk);
    ones = 0;
    repeat (48) begin
      @(negedge clk);
      ones += 32'(pwm0);
    end
    check("pwm_high_count_48", 0, ones, 15);

    pulse(1, 1'b0, 1'b1, c);
    expect_at(c + 1, 1, F_LEVEL, 3);
    expect_at(c + 3, 1, F_DUTY,  15);
    expect_at(c + 4, 1, F_PWM,   1);
    repeat (4) @(negedge clk);
    pulse(1, 1'b1, 1'b0, c);
    expect_at(c + 1, 1, F_LEVEL, 0);
    expect_at(c + 3, 1, F_DUTY,  0);
    expect_at(c + 4, 1, F_PWM,   0);
    repeat (4) @(negedge clk);
    pulse(1, 1'b0, 1'b1, c);
    expect_at(c + 1, 1, F_LEVEL, 3);
    expect_at(c + 3, 1, F_DUTY,  15);
    expect_at(c + 4, 1, F_PWM,   1);
    repeat (5) @(negedge clk);

    async_reset_check(0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    up0 = 1'b0; dn0 = 1'b0; en0 = 1'b1;
    up1 = 1'b0; dn1 = 1'b0; en1 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned d = 0; d < 2; d++) begin
      expect_at(cyc + 1, d, F_LEVEL, 0);
      expect_at(cyc + 1, d, F_DUTY,  0);
      expect_at(cyc + 1, d, F_BUSY,  0);
      expect_at(cyc + 1, d, F_PWM,   0);
    end
    repeat (3) @(negedge clk);
`ifdef FAN_SOFT_START_EN
    ramp_tests();
`else
    basic_tests();
`endif
    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL pending_%s dut%0d: stamp %0d never compared",
               fname(sb[0].fld), sb[0].dut, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
